// File: rtl/equiv_sweep_pkg.sv
// equiv_sweep_pkg: sweep FSM state encoding and width helpers shared by the equivalence sweeper.
package equiv_sweep_pkg;
   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   function automatic int vec_count(input int n_in);
      return 1 << n_in;
   endfunction

   function automatic int timer_width(input int settle_cycles);
      return $clog2(settle_cycles) + 1;
   endfunction
endpackage

// File: rtl/sweep_settle_timer.sv
// sweep_settle_timer: loadable down-counter that flags when the settle window has elapsed.
module sweep_settle_timer
   import equiv_sweep_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic zero
);
   localparam int W = timer_width(SETTLE_CYCLES);
   logic [W-1:0] count;
   assign zero = count == '0;
   // Counts down freely and parks at zero; the FSM reloads it on every SETTLE entry.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) count <= '0;
      else count <= load ? W'(SETTLE_CYCLES - 1) : (zero ? count : count - 1'b1);
endmodule

// File: rtl/equiv_sweep_checker.sv
// equiv_sweep_checker: sweeps every input vector into two circuits and compares their outputs.
// Define SWEEP_STOP_ON_MISMATCH_EN to end the sweep at the first mismatching vector.
module equiv_sweep_checker
   import equiv_sweep_pkg::*;
#(
   parameter int N_IN          = 4,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     dut_a_out,
   input  logic                     dut_b_out,
   output logic [N_IN-1:0]          stim,
   output logic                     busy,
   output logic                     done,
   output logic                     equal,
   output logic [N_IN:0]            mismatch_count,
   output logic [N_IN-1:0]          first_mm_vec,
   output logic [vec_count(N_IN)-1:0] tt_a,
   output logic [vec_count(N_IN)-1:0] tt_b
);
   state_t state, state_nx;
   logic load, zero, mm, last, stop;

   sweep_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
      .clk  (clk),
      .rst_n(rst_n),
      .load (load),
      .zero (zero)
   );

   assign mm   = dut_a_out ^ dut_b_out;
   assign last = &stim;
`ifdef SWEEP_STOP_ON_MISMATCH_EN
   assign stop = last | mm;
`else
   assign stop = last;
`endif

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      case (state)
         IDLE: begin
            state_nx = start ? SETTLE : IDLE;
            load     = start;
         end
         SETTLE: state_nx = zero ? SAMPLE : SETTLE;
         SAMPLE: begin
            state_nx = stop ? DONE : SETTLE;
            load     = !stop;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         stim           <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         equal          <= 1'b0;
         mismatch_count <= '0;
         first_mm_vec   <= '0;
         tt_a           <= '0;
         tt_b           <= '0;
      end else if (state == IDLE && start) begin
         stim           <= '0;
         busy           <= 1'b1;
         done           <= 1'b0;
         equal          <= 1'b0;
         mismatch_count <= '0;
         first_mm_vec   <= '0;
         tt_a           <= '0;
         tt_b           <= '0;
      end else if (state == SAMPLE) begin
         tt_a[stim] <= dut_a_out;
         tt_b[stim] <= dut_b_out;
         if (mm) mismatch_count <= mismatch_count + 1'b1;
         if (mm && mismatch_count == '0) first_mm_vec <= stim;
         if (!stop) stim <= stim + 1'b1;
      end else if (state == DONE) begin
         busy  <= 1'b0;
         done  <= 1'b1;
         equal <= mismatch_count == '0;
      end
endmodule
